thirty_two_bit_bskip_sub_seq: RTL and testbench

//   Sequential 32-bit borrow-skip subtractor: D = A - B - BIN. It is the subtract-direction

---
 rtl/thirty_two_bit_bskip_sub_seq_if.sv | 32 +++
 rtl/thirty_two_bit_bskip_sub_seq.sv | 125 ++++++++++++
 tb/tb_thirty_two_bit_bskip_sub_seq.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/thirty_two_bit_bskip_sub_seq_if.sv
// Operand/result handshake bundle for the sequential borrow-skip subtractor.
// The master side supplies operands and consumes results; the slave side is the datapath.
interface thirty_two_bit_bskip_sub_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
);
    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned CW = $clog2(NG) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;
    logic             ovf;
    logic [CW-1:0]    skip_cnt;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, zero, ovf, skip_cnt
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, zero, ovf, skip_cnt
    );
endinterface

// File: rtl/thirty_two_bit_bskip_sub_seq.sv
// Sequential borrow-skip subtractor: D = A - B - BIN, one GROUP-bit slice per clock,
// LSB first, with a registered borrow that bypasses slices whose operand digits match.
module thirty_two_bit_bskip_sub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned GROUP = 4
) (
    input logic                           clk,
    input logic                           rst_n,
    thirty_two_bit_bskip_sub_seq_if.slave bus
);
    localparam int unsigned NG = WIDTH / GROUP;
    localparam int unsigned IW = (NG > 1) ? $clog2(NG) : 1;
    localparam int unsigned CW = $clog2(NG) + 1;
    localparam int unsigned LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic [IW-1:0]    idx_q;
    logic             br_q;
    logic             bout_q;
    logic             zero_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CW-1:0]    skip_cnt_q;

    logic [LW-1:0]    base;
    logic [GROUP-1:0] a_g;
    logic [GROUP-1:0] b_g;
    logic [GROUP:0]   diff;
    logic             ripple_b;
    logic             p;
    logic             br_d;
    logic [WIDTH-1:0] d_d;

    // Current slice: ripple borrow is computed, but matching digits hand the incoming
    // borrow straight through, which is also what the ripple result would give.
    always_comb begin
        base     = LW'(32'(idx_q) * GROUP);
        a_g      = a_q[base +: GROUP];
        b_g      = b_q[base +: GROUP];
        diff     = {1'b0, a_g} - {1'b0, b_g} - {{GROUP{1'b0}}, br_q};
        ripple_b = diff[GROUP];
        p        = (a_g == b_g);
        br_d     = p ? br_q : ripple_b;
        d_d      = d_q;
        d_d[base +: GROUP] = diff[GROUP-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            idx_q       <= '0;
            br_q        <= 1'b0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            skip_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        br_q       <= bus.bin;
                        idx_q      <= '0;
                        skip_cnt_q <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    d_q  <= d_d;
                    br_q <= br_d;
                    if (p) begin
                        skip_cnt_q <= skip_cnt_q + CW'(1);
                    end
                    if (idx_q == IW'(NG - 1)) begin
                        bout_q      <= br_d;
                        zero_q      <= (d_d == '0);
                        ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                       (d_d[WIDTH-1] != a_q[WIDTH-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.skip_cnt  = skip_cnt_q;
endmodule

// File: tb/tb_thirty_two_bit_bskip_sub_seq.sv
// Bench for the borrow-skip subtractor: a 32/4 and a 16/2 instance run in lockstep
// against a whole-word arithmetic model, plus literal vectors and timing/reset cases.
module tb_thirty_two_bit_bskip_sub_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    thirty_two_bit_bskip_sub_seq_if #(.WIDTH(32), .GROUP(4)) if32 ();
    thirty_two_bit_bskip_sub_seq_if #(.WIDTH(16), .GROUP(2)) if16 ();

    thirty_two_bit_bskip_sub_seq #(.WIDTH(32), .GROUP(4)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32)
    );

    thirty_two_bit_bskip_sub_seq #(.WIDTH(16), .GROUP(2)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16)
    );

    // Model expectations for the operation currently in flight.
    logic [31:0] e32_d;
    logic        e32_bout, e32_zero, e32_ovf;
    int          e32_skip;
    logic [15:0] e16_d;
    logic        e16_bout, e16_zero, e16_ovf;
    int          e16_skip;
    logic        hold32 = 1'b0;
    logic        hold16 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int count_skips(input logic [31:0] a, input logic [31:0] b,
                                       input int w, input int g);
        int          n = 0;
        logic [31:0] m = (32'd1 << g) - 32'd1;
        for (int i = 0; i < w / g; i++) begin
            if (((a >> (i * g)) & m) == ((b >> (i * g)) & m)) n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            hold32 <= 1'b0;
            hold16 <= 1'b0;
        end else begin
            if (hold32) chk("hold32_valid", 64'(if32.out_valid), 64'd1);
            if (hold16) chk("hold16_valid", 64'(if16.out_valid), 64'd1);
            if (if32.out_valid) begin
                chk("m32_d", 64'(if32.d), 64'(e32_d));
                chk("m32_bout", 64'(if32.bout), 64'(e32_bout));
                chk("m32_zero", 64'(if32.zero), 64'(e32_zero));
                chk("m32_ovf", 64'(if32.ovf), 64'(e32_ovf));
                chk("m32_skip", 64'(if32.skip_cnt), 64'(e32_skip));
                chk("m32_in_ready", 64'(if32.in_ready), 64'd0);
            end
            if (if16.out_valid) begin
                chk("m16_d", 64'(if16.d), 64'(e16_d));
                chk("m16_bout", 64'(if16.bout), 64'(e16_bout));
                chk("m16_zero", 64'(if16.zero), 64'(e16_zero));
                chk("m16_ovf", 64'(if16.ovf), 64'(e16_ovf));
                chk("m16_skip", 64'(if16.skip_cnt), 64'(e16_skip));
                chk("m16_in_ready", 64'(if16.in_ready), 64'd0);
            end
            hold32 <= if32.out_valid && !if32.out_ready;
            hold16 <= if16.out_valid && !if16.out_ready;
        end
    end

    task automatic start(input logic [31:0] a, input logic [31:0] b, input logic bn,
                         input logic [15:0] a2, input logic [15:0] b2, input logic bn2);
        int          n = 0;
        logic [32:0] r32;
        logic [16:0] r16;
        while (!(if32.in_ready && if16.in_ready) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 40) begin
            failures++;
            $display("FAIL in_ready_wait: got timeout expected in_ready=1");
        end
        r32      = {1'b0, a} - {1'b0, b} - 33'(bn);
        e32_d    = r32[31:0];
        e32_bout = r32[32];
        e32_zero = (r32[31:0] == 32'd0);
        e32_ovf  = (a[31] != b[31]) && (r32[31] != a[31]);
        e32_skip = count_skips(a, b, 32, 4);
        r16      = {1'b0, a2} - {1'b0, b2} - 17'(bn2);
        e16_d    = r16[15:0];
        e16_bout = r16[16];
        e16_zero = (r16[15:0] == 16'd0);
        e16_ovf  = (a2[15] != b2[15]) && (r16[15] != a2[15]);
        e16_skip = count_skips({16'd0, a2}, {16'd0, b2}, 16, 2);
        if32.a = a;   if32.b = b;   if32.bin = bn;  if32.in_valid = 1'b1;
        if16.a = a2;  if16.b = b2;  if16.bin = bn2; if16.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        if16.in_valid = 1'b0;
        if32.a = $urandom;
        if32.b = $urandom;
    endtask

    task automatic wait_done();
        int lat = 0;
        while (!(if32.out_valid && if16.out_valid) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd8);
    endtask

    task automatic finish_op(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        if32.out_ready = 1'b1;
        if16.out_ready = 1'b1;
        @(posedge clk);
        #1;
        if32.out_ready = 1'b0;
        if16.out_ready = 1'b0;
        chk("post_hs_valid", 64'(if32.out_valid), 64'd0);
        chk("post_hs_ready", 64'(if32.in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bn, input int hold);
        start(a, b, bn, 16'($urandom), 16'($urandom), 1'($urandom));
        wait_done();
        finish_op(hold);
    endtask

    function automatic logic [31:0] pick_b(input logic [31:0] a, input int sel);
        logic [31:0] b;
        case (sel)
            0: b = a;
            1: b = a ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, 7)));
            2: b = (a[0]) ? 32'hFFFFFFFF : 32'h0;
            default: b = $urandom;
        endcase
        return b;
    endfunction

    initial begin
        logic [31:0] d_snap;
        logic [31:0] ra, rb;
        logic [15:0] ra2, rb2;
        if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.a = '0; if32.b = '0; if32.bin = 1'b0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
        #12;
        chk("rst_in_ready", 64'(if32.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
        chk("rst_d", 64'(if32.d), 64'd0);
        chk("rst_flags", 64'({if32.bout, if32.zero, if32.ovf}), 64'd0);
        chk("rst_skip", 64'(if32.skip_cnt), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        start(32'h00000005, 32'h00000003, 1'b0, 16'h0001, 16'h0002, 1'b0);
        wait_done();
        chk("v1_d", 64'(if32.d), 64'h2);
        chk("v1_flags", 64'({if32.bout, if32.zero, if32.ovf}), 64'd0);
        chk("v1_skip", 64'(if32.skip_cnt), 64'd7);
        chk("v1_d16", 64'(if16.d), 64'hFFFF);
        finish_op(0);

        start(32'h00000000, 32'h00000001, 1'b0, 16'h8000, 16'h0001, 1'b0);
        wait_done();
        chk("v2_d", 64'(if32.d), 64'hFFFFFFFF);
        chk("v2_bout", 64'(if32.bout), 64'd1);
        chk("v2_ovf", 64'(if32.ovf), 64'd0);
        chk("v2_skip", 64'(if32.skip_cnt), 64'd7);
        chk("v2_ovf16", 64'(if16.ovf), 64'd1);
        finish_op(0);

        start(32'h80000000, 32'h00000001, 1'b0, 16'h1234, 16'h1234, 1'b1);
        wait_done();
        chk("v3_d", 64'(if32.d), 64'h7FFFFFFF);
        chk("v3_bout", 64'(if32.bout), 64'd0);
        chk("v3_ovf", 64'(if32.ovf), 64'd1);
        chk("v3_skip", 64'(if32.skip_cnt), 64'd6);
        chk("v3_skip16", 64'(if16.skip_cnt), 64'd8);
        finish_op(0);

        start(32'h12345678, 32'h12345678, 1'b1, 16'h0007, 16'h0007, 1'b0);
        wait_done();
        chk("v4_d", 64'(if32.d), 64'hFFFFFFFF);
        chk("v4_bout", 64'(if32.bout), 64'd1);
        chk("v4_zero", 64'(if32.zero), 64'd0);
        chk("v4_skip", 64'(if32.skip_cnt), 64'd8);
        d_snap = if32.d;
        // Back-pressure: results must hold across five stalled cycles.
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("bp_d", 64'(if32.d), 64'(d_snap));
        chk("bp_valid", 64'(if32.out_valid), 64'd1);
        chk("bp_in_ready", 64'(if32.in_ready), 64'd0);
        finish_op(0);

        start(32'hFFFFFFFF, 32'h00000000, 1'b0, 16'hFFFF, 16'h0000, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(if32.out_valid), 64'd0);
        chk("abort_ready", 64'(if32.in_ready), 64'd1);
        chk("abort_d", 64'(if32.d), 64'd0);
        chk("abort_skip", 64'(if32.skip_cnt), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        start(32'h00000007, 32'h00000007, 1'b0, 16'h0007, 16'h0007, 1'b0);
        wait_done();
        chk("v5_d", 64'(if32.d), 64'd0);
        chk("v5_zero", 64'(if32.zero), 64'd1);
        chk("v5_bout", 64'(if32.bout), 64'd0);
        chk("v5_zero16", 64'(if16.zero), 64'd1);
        finish_op(1);

        for (int n = 0; n < 2000; n++) begin
            ra  = $urandom;
            rb  = pick_b(ra, int'($urandom_range(0, 5)));
            ra2 = 16'($urandom);
            rb2 = ($urandom_range(0, 3) == 0) ? ra2 : 16'($urandom);
            start(ra, rb, 1'($urandom), ra2, rb2, 1'($urandom));
            wait_done();
            finish_op(int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
